id_stage_pipe: RTL

- Parametrised decode stage with an internal ID/EX pipeline register and valid/ready handshakes on both sides.
- Decodes RV32I/RV32E instructions and reads operands from an internal register file with a write-back bypass.
- Detects load-use hazards against the instruction held in its own output register and inserts bubbles; supports flush.
- Sits between the IF/ID register and the EX stage; keeps a saturating stall counter for performance analysis.

---
 rtl/decode_pkg.sv | 50 +++++
 rtl/decode_ctrl_ext.sv | 144 ++++++++++++++
 rtl/id_stage_pipe.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared decode definitions for the ID stage: RV32I base opcodes, ALU
// operation classes, special instruction words, the control bundle carried
// into EX and an index-legality helper used for RV32E builds.
// -----------------------------------------------------------------------------
package decode_pkg;

    // Base opcodes (instr[6:0])
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // ALU operation classes handed to EX
    localparam logic [1:0] ALUOP_MEM  = 2'b00;
    localparam logic [1:0] ALUOP_BR   = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;
    localparam logic [1:0] ALUOP_UJ   = 2'b11;

    // Special instruction words
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [31:0] ECALL_INSTR = 32'h0000_0073;
    localparam logic [31:0] MRET_INSTR  = 32'h3020_0073;

    // Control bundle registered into the ID/EX stage
    typedef struct packed {
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       alusrc;
        logic       branch;
        logic [1:0] aluop;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = ctrl_t'(8'h00);

    // A register index is legal when it lies below the implemented count
    function automatic logic idx_legal(input logic [4:0] idx, input logic [5:0] nregs);
        return ({1'b0, idx} < nregs);
    endfunction

endpackage : decode_pkg

// File: rtl/decode_ctrl_ext.sv
// -----------------------------------------------------------------------------
// decode_ctrl_ext
// Combinational opcode decode for the ID stage.
//   instr     in   32  instruction word from IF/ID
//   ctrl      out  ctrl_t  control bundle (illegal words have side effects cleared)
//   uses_rs1  out  1   instruction reads rs1 (used for hazard detection)
//   uses_rs2  out  1   instruction reads rs2
//   illegal   out  1   bad opcode, bad SYSTEM word or out-of-range register index
//   is_ecall  out  1   ECALL recognised
//   is_mret   out  1   MRET recognised
// Build option: define ID_SYSTEM_DECODE_EN to recognise ECALL/MRET and to reject
// every other SYSTEM word; otherwise SYSTEM words are legal no-ops and both
// flags are tied low.
// -----------------------------------------------------------------------------
module decode_ctrl_ext
    import decode_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic        uses_rs1,
    output logic        uses_rs2,
    output logic        illegal,
    output logic        is_ecall,
    output logic        is_mret
);

    localparam logic [5:0] NREGS_C = 6'(NUM_REGS);

    logic [6:0] opcode_s;
    logic [4:0] rd_s;
    logic [4:0] rs1_s;
    logic [4:0] rs2_s;
    ctrl_t      ctrl_raw_s;
    logic       bad_opcode_s;
    logic       bad_system_s;
    logic       bad_index_s;

    assign opcode_s = instr[6:0];
    assign rd_s     = instr[11:7];
    assign rs1_s    = instr[19:15];
    assign rs2_s    = instr[24:20];

    // Opcode to control bundle, operand usage and system recognition
    always_comb begin
        ctrl_raw_s   = CTRL_NONE;
        uses_rs1     = 1'b0;
        uses_rs2     = 1'b0;
        bad_opcode_s = 1'b0;
        bad_system_s = 1'b0;
        is_ecall     = 1'b0;
        is_mret      = 1'b0;
        case (opcode_s)
            OPC_OP: begin
                ctrl_raw_s.regwrite = 1'b1;
                ctrl_raw_s.aluop    = ALUOP_FUNC;
                uses_rs1            = 1'b1;
                uses_rs2            = 1'b1;
            end
            OPC_OP_IMM: begin
                // The canonical NOP carries no controls at all so EX sees a pure bubble
                if (instr == NOP_INSTR) begin
                    ctrl_raw_s = CTRL_NONE;
                end else begin
                    ctrl_raw_s.regwrite = 1'b1;
                    ctrl_raw_s.alusrc   = 1'b1;
                    ctrl_raw_s.aluop    = ALUOP_FUNC;
                    uses_rs1            = 1'b1;
                end
            end
            OPC_LOAD: begin
                ctrl_raw_s.regwrite = 1'b1;
                ctrl_raw_s.memread  = 1'b1;
                ctrl_raw_s.memtoreg = 1'b1;
                ctrl_raw_s.alusrc   = 1'b1;
                ctrl_raw_s.aluop    = ALUOP_MEM;
                uses_rs1            = 1'b1;
            end
            OPC_STORE: begin
                ctrl_raw_s.memwrite = 1'b1;
                ctrl_raw_s.alusrc   = 1'b1;
                ctrl_raw_s.aluop    = ALUOP_MEM;
                uses_rs1            = 1'b1;
                uses_rs2            = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl_raw_s.branch = 1'b1;
                ctrl_raw_s.aluop  = ALUOP_BR;
                uses_rs1          = 1'b1;
                uses_rs2          = 1'b1;
            end
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                ctrl_raw_s.regwrite = 1'b1;
                ctrl_raw_s.alusrc   = 1'b1;
                ctrl_raw_s.aluop    = ALUOP_UJ;
            end
            OPC_JALR: begin
                ctrl_raw_s.regwrite = 1'b1;
                ctrl_raw_s.alusrc   = 1'b1;
                ctrl_raw_s.aluop    = ALUOP_UJ;
                uses_rs1            = 1'b1;
            end
            OPC_SYSTEM: begin
`ifdef ID_SYSTEM_DECODE_EN
                if (instr == ECALL_INSTR) begin
                    is_ecall = 1'b1;
                end else if (instr == MRET_INSTR) begin
                    is_mret = 1'b1;
                end else begin
                    bad_system_s = 1'b1;
                end
`else
                bad_system_s = 1'b0;
`endif
            end
            default: begin
                bad_opcode_s = 1'b1;
            end
        endcase
    end

    // Index legality only matters for RV32E; rd counts only if it is written
    always_comb begin
        bad_index_s = (uses_rs1 & ~idx_legal(rs1_s, NREGS_C))
                    | (uses_rs2 & ~idx_legal(rs2_s, NREGS_C))
                    | (ctrl_raw_s.regwrite & ~idx_legal(rd_s, NREGS_C));
    end

    // Illegal words must not change architectural or memory state downstream
    always_comb begin
        illegal = bad_opcode_s | bad_system_s | bad_index_s;
        ctrl    = ctrl_raw_s;
        if (illegal) begin
            ctrl.regwrite = 1'b0;
            ctrl.memread  = 1'b0;
            ctrl.memwrite = 1'b0;
            ctrl.branch   = 1'b0;
        end else begin
            ctrl = ctrl_raw_s;
        end
    end

endmodule : decode_ctrl_ext

// File: rtl/id_stage_pipe.sv
// -----------------------------------------------------------------------------
// id_stage_pipe
// RV32I/RV32E decode stage with register file, write-back bypass, load-use
// hazard bubble insertion, flush and an ID/EX output register.
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          IF/ID side handshake; in_pc, in_instr payload
//   flush                      drop incoming instruction and invalidate output
//   wb_regwrite/wb_rd/wb_wdata write-back port into the register file
//   out_valid/out_ready        EX side handshake
//   ex_*                       registered PC, operands, immediate, indices,
//                              funct fields, controls and system flags
//   stall_cnt                  saturating count of hazard stall cycles
// Build option: ID_SYSTEM_DECODE_EN (see decode_ctrl_ext).
// -----------------------------------------------------------------------------
module id_stage_pipe
    import decode_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NUM_REGS  = 32,
    parameter int WB_BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instr,
    input  logic            flush,
    input  logic            wb_regwrite,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_wdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
    output logic [6:0]      ex_funct7,
    output logic            ex_regwrite,
    output logic            ex_memread,
    output logic            ex_memwrite,
    output logic            ex_memtoreg,
    output logic            ex_alusrc,
    output logic            ex_branch,
    output logic [1:0]      ex_aluop,
    output logic            ex_illegal,
    output logic            ex_is_ecall,
    output logic            ex_is_mret,
    output logic [31:0]     stall_cnt
);

    localparam int         IDXW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [5:0] NREGS_C  = 6'(NUM_REGS);
    localparam logic       BYPASS_C = (WB_BYPASS != 0);

    logic [XLEN-1:0] rf_r [NUM_REGS];

    logic [4:0]        rs1_s;
    logic [4:0]        rs2_s;
    ctrl_t             ctrl_s;
    logic              uses_rs1_s;
    logic              uses_rs2_s;
    logic              illegal_s;
    logic              is_ecall_s;
    logic              is_mret_s;
    logic              wb_we_s;
    logic [XLEN-1:0]   rs1_data_s;
    logic [XLEN-1:0]   rs2_data_s;
    logic signed [31:0] imm32_s;
    logic [XLEN-1:0]   imm_s;
    logic              hazard_s;
    logic              capture_s;
    logic              stall_inc_s;

    assign rs1_s = in_instr[19:15];
    assign rs2_s = in_instr[24:20];

    decode_ctrl_ext #(
        .NUM_REGS (NUM_REGS)
    ) u_decode (
        .instr    (in_instr),
        .ctrl     (ctrl_s),
        .uses_rs1 (uses_rs1_s),
        .uses_rs2 (uses_rs2_s),
        .illegal  (illegal_s),
        .is_ecall (is_ecall_s),
        .is_mret  (is_mret_s)
    );

    // Write-back enable: x0 and unimplemented registers are never written
    always_comb begin
        wb_we_s = wb_regwrite & (wb_rd != 5'd0) & idx_legal(wb_rd, NREGS_C);
    end

    // Register file write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_r[i] <= {XLEN{1'b0}};
            end
        end else if (wb_we_s) begin
            rf_r[wb_rd[IDXW-1:0]] <= wb_wdata;
        end
    end

    // rs1 read port with optional same-cycle write-back forwarding
    always_comb begin
        rs1_data_s = {XLEN{1'b0}};
        if (rs1_s == 5'd0) begin
            rs1_data_s = {XLEN{1'b0}};
        end else if (!idx_legal(rs1_s, NREGS_C)) begin
            rs1_data_s = {XLEN{1'b0}};
        end else if (BYPASS_C && wb_we_s && (wb_rd == rs1_s)) begin
            rs1_data_s = wb_wdata;
        end else begin
            rs1_data_s = rf_r[rs1_s[IDXW-1:0]];
        end
    end

    // rs2 read port with optional same-cycle write-back forwarding
    always_comb begin
        rs2_data_s = {XLEN{1'b0}};
        if (rs2_s == 5'd0) begin
            rs2_data_s = {XLEN{1'b0}};
        end else if (!idx_legal(rs2_s, NREGS_C)) begin
            rs2_data_s = {XLEN{1'b0}};
        end else if (BYPASS_C && wb_we_s && (wb_rd == rs2_s)) begin
            rs2_data_s = wb_wdata;
        end else begin
            rs2_data_s = rf_r[rs2_s[IDXW-1:0]];
        end
    end

    // Immediate generation; built as 32 bits and sign-extended to XLEN
    always_comb begin
        imm32_s = 32'sd0;
        case (in_instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM:
                imm32_s = {{20{in_instr[31]}}, in_instr[31:20]};
            OPC_STORE:
                imm32_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            OPC_BRANCH:
                imm32_s = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm32_s = {in_instr[31:12], 12'h000};
            OPC_JAL:
                imm32_s = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
            default:
                imm32_s = 32'sd0;
        endcase
        imm_s = XLEN'(imm32_s);
    end

    // Load-use hazard against the load currently held in the output register
    always_comb begin
        hazard_s = out_valid & ex_memread & (ex_rd != 5'd0)
                 & ((uses_rs1_s & (rs1_s == ex_rd)) | (uses_rs2_s & (rs2_s == ex_rd)));
    end

    // Input handshake; flush always drains IF/ID
    always_comb begin
        if (flush) begin
            in_ready = 1'b1;
        end else begin
            in_ready = (~out_valid | out_ready) & ~hazard_s;
        end
        capture_s   = in_valid & in_ready & ~flush;
        stall_inc_s = in_valid & hazard_s & ~flush;
    end

    // ID/EX pipeline register: flush wins, then capture, then drain on transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            ex_pc       <= {XLEN{1'b0}};
            ex_rs1_data <= {XLEN{1'b0}};
            ex_rs2_data <= {XLEN{1'b0}};
            ex_imm      <= {XLEN{1'b0}};
            ex_rs1      <= 5'd0;
            ex_rs2      <= 5'd0;
            ex_rd       <= 5'd0;
            ex_funct3   <= 3'd0;
            ex_funct7   <= 7'd0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_alusrc   <= 1'b0;
            ex_branch   <= 1'b0;
            ex_aluop    <= 2'b00;
            ex_illegal  <= 1'b0;
            ex_is_ecall <= 1'b0;
            ex_is_mret  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture_s) begin
            out_valid   <= 1'b1;
            ex_pc       <= in_pc;
            ex_rs1_data <= rs1_data_s;
            ex_rs2_data <= rs2_data_s;
            ex_imm      <= imm_s;
            ex_rs1      <= rs1_s;
            ex_rs2      <= rs2_s;
            ex_rd       <= in_instr[11:7];
            ex_funct3   <= in_instr[14:12];
            ex_funct7   <= in_instr[31:25];
            ex_regwrite <= ctrl_s.regwrite;
            ex_memread  <= ctrl_s.memread;
            ex_memwrite <= ctrl_s.memwrite;
            ex_memtoreg <= ctrl_s.memtoreg;
            ex_alusrc   <= ctrl_s.alusrc;
            ex_branch   <= ctrl_s.branch;
            ex_aluop    <= ctrl_s.aluop;
            ex_illegal  <= illegal_s;
            ex_is_ecall <= is_ecall_s;
            ex_is_mret  <= is_mret_s;
        end else if (out_ready) begin
            // EX took the held instruction and nothing new arrived: bubble
            out_valid <= 1'b0;
        end
    end

    // Saturating hazard stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 32'd0;
        end else if (stall_inc_s && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule : id_stage_pipe
